a1_scaler: RTL and testbench

A1_SCALER -- requirements
Module: a1_scaler

---
 rtl/a1_scaler_pkg.sv | 20 ++
 rtl/a1_scaler_edge.sv | 40 ++++
 rtl/a1_scaler.sv | 55 +++++
 tb/tb_a1_scaler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/a1_scaler_pkg.sv
// Shared timing constants for the A1 scaler chain and its downstream consumers.
// Stage F(n) sits at bit (n-2) of the scaler's FS/FA/FB vectors.
package a1_scaler_pkg;

  localparam int          NSTG_DEF       = 32;
  localparam logic [15:0] FAIL_LIMIT_DEF = 16'd8192;

  function automatic int stage_idx(input int fnum);
    return fnum - 2;
  endfunction

  localparam int F05_IDX = stage_idx(5);
  localparam int F07_IDX = stage_idx(7);
  localparam int F09_IDX = stage_idx(9);
  localparam int F10_IDX = stage_idx(10);
  localparam int F12_IDX = stage_idx(12);
  localparam int F17_IDX = stage_idx(17);
  localparam int F18_IDX = stage_idx(18);

endpackage

// File: rtl/a1_scaler_edge.sv
// FS01 rising-edge detector plus the scaler-fail watchdog that raises SCAFAL
// when FS01 stops producing rising edges.
module a1_scaler_edge
  import a1_scaler_pkg::*;
#(
  parameter logic [15:0] FAIL_LIMIT = FAIL_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic fs01,
  output logic fs01_rise,
  output logic scafal
);

  logic        fs01_q;
  logic        armed;
  logic [15:0] wd;

  // armed blocks a spurious edge when FS01 is already high as reset releases:
  // a rise only counts once FS01 has been observed low.
  assign fs01_rise = fs01 & ~fs01_q & armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      fs01_q <= 1'b0;
      armed  <= 1'b0;
      wd     <= 16'd0;
      scafal <= 1'b0;
    end else begin
      fs01_q <= fs01;
      armed  <= armed | ~fs01;
      if (fs01_rise)
        wd <= 16'd0;
      else if (wd < FAIL_LIMIT)
        wd <= wd + 16'd1;
      scafal <= ~fs01_rise & (wd == FAIL_LIMIT);
    end
  end

endmodule

// File: rtl/a1_scaler.sv
// A1 scaler: NSTG-bit binary count of FS01 rising edges (stages F02..F(NSTG+1))
// with per-stage rise (FA) and fall (FB) pulses and a scaler-fail alarm.
module a1_scaler
  import a1_scaler_pkg::*;
#(
  parameter logic [15:0] FAIL_LIMIT = FAIL_LIMIT_DEF,
  parameter int          NSTG       = NSTG_DEF
) (
  input  logic            SIM_CLK,
  input  logic            SIM_RST,
  input  logic            FS01,
  input  logic            SCLCLR,
  output logic [NSTG-1:0] FS,
  output logic [NSTG-1:0] FA,
  output logic [NSTG-1:0] FB,
  output logic            SCAFAL
);

  logic            fs01_rise;
  logic [NSTG-1:0] cnt_nxt;

  a1_scaler_edge #(
    .FAIL_LIMIT(FAIL_LIMIT)
  ) u_edge (
    .clk      (SIM_CLK),
    .rst      (SIM_RST),
    .fs01     (FS01),
    .fs01_rise(fs01_rise),
    .scafal   (SCAFAL)
  );

  assign cnt_nxt = FS + NSTG'(1);

  // FA/FB are registered alongside FS so each pulse lines up with the cycle
  // in which the new stage level first appears.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      FS <= '0;
      FA <= '0;
      FB <= '0;
    end else if (SCLCLR) begin
      FS <= '0;
      FA <= '0;
      FB <= '0;
    end else if (fs01_rise) begin
      FS <= cnt_nxt;
      FA <= ~FS & cnt_nxt;
      FB <= FS & ~cnt_nxt;
    end else begin
      FA <= '0;
      FB <= '0;
    end
  end

endmodule

// File: tb/tb_a1_scaler.sv
// Scoreboard bench for a1_scaler (NSTG=4, FAIL_LIMIT=100): a behavioural model
// pushes expected outputs per cycle and a monitor pops and compares them.
module tb_a1_scaler;

  localparam int N   = 4;
  localparam int LIM = 100;
  localparam int W   = 3 * N + 1;

  logic         clk;
  logic         rst;
  logic         fs01;
  logic         sclclr;
  logic [N-1:0] fs;
  logic [N-1:0] fa;
  logic [N-1:0] fb;
  logic         scafal;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  a1_scaler #(
    .FAIL_LIMIT(16'(LIM)),
    .NSTG      (N)
  ) dut (
    .SIM_CLK(clk),
    .SIM_RST(rst),
    .FS01   (fs01),
    .SCLCLR (sclclr),
    .FS     (fs),
    .FA     (fa),
    .FB     (fb),
    .SCAFAL (scafal)
  );

  // reference model: count of qualified FS01 rises, idle-cycle counter, last level
  int           m_cnt;
  int           m_idle;
  int           m_prev;   // -1 = level unknown (just out of reset)
  logic [N-1:0] m_fa;
  logic [N-1:0] m_fb;
  logic         m_alarm;

  logic [W-1:0] exp_q[$];

  // pulse statistics gathered from the DUT by the monitor
  int fa0_cnt = 0;
  int fa1_cnt = 0;
  int fb0_cnt = 0;
  int fball_cnt = 0;
  int any_pulse_cnt = 0;

  // driver: apply inputs for one cycle and predict the state after the next edge
  task automatic step(input logic f, input logic c, input logic r);
    int  old_cnt;
    bit  rise;
    @(negedge clk);
    fs01   = f;
    sclclr = c;
    rst    = r;
    if (r) begin
      m_cnt = 0; m_idle = 0; m_prev = -1; m_alarm = 1'b0;
      m_fa = '0; m_fb = '0;
    end else begin
      rise    = (f == 1'b1) && (m_prev == 0);
      old_cnt = m_cnt;
      m_fa = '0;
      m_fb = '0;
      if (c)
        m_cnt = 0;
      else if (rise) begin
        m_cnt = (m_cnt + 1) % (1 << N);
        for (int k = 0; k < N; k++) begin
          m_fa[k] = (((m_cnt >> k) & 1) == 1) && (((old_cnt >> k) & 1) == 0);
          m_fb[k] = (((m_cnt >> k) & 1) == 0) && (((old_cnt >> k) & 1) == 1);
        end
      end
      m_alarm = !rise && (m_idle >= LIM);
      m_idle  = rise ? 0 : m_idle + 1;
      m_prev  = f ? 1 : 0;
    end
    exp_q.push_back({N'(m_cnt), m_fa, m_fb, m_alarm});
  endtask

  task automatic pulse(input int hi, input int lo);
    repeat (hi) step(1'b1, 1'b0, 1'b0);
    repeat (lo) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // sample DUT just after the edge that follows the last step
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {fs, fa, fb, scafal};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got fs=%h fa=%h fb=%h scafal=%b expected fs=%h fa=%h fb=%h scafal=%b",
                 $time, fs, fa, fb, scafal, e[W-1 -: N], e[2*N -: N], e[N -: N], e[0]);
      end
      if (fa[0]) fa0_cnt++;
      if (fa[1]) fa1_cnt++;
      if (fb[0]) fb0_cnt++;
      if (fb == '1) fball_cnt++;
      if ((fa | fb) != '0) any_pulse_cnt++;
    end
  end

  initial begin
    int len;
    logic lvl;
    rst = 1'b1; fs01 = 1'b0; sclclr = 1'b0;
    m_cnt = 0; m_idle = 0; m_prev = -1; m_alarm = 1'b0; m_fa = '0; m_fb = '0;

    // reset state
    do_reset();
    settle();
    check("reset_fs", int'(fs), 0);
    check("reset_scafal", int'(scafal), 0);

    // five slow pulses
    fa0_cnt = 0; fa1_cnt = 0; fb0_cnt = 0;
    repeat (5) pulse(40, 40);
    settle();
    check("five_pulses_fs", int'(fs), 5);
    check("five_pulses_fa0", fa0_cnt, 3);
    check("five_pulses_fa1", fa1_cnt, 1);
    check("five_pulses_fb0", fb0_cnt, 2);

    // drive to all-ones, then wrap
    repeat (10) pulse(2, 2);
    settle();
    check("all_ones_fs", int'(fs), 15);
    fball_cnt = 0;
    pulse(2, 2);
    settle();
    check("wrap_fs", int'(fs), 0);
    check("wrap_fb_all", fball_cnt, 1);

    // clear coinciding with an edge at count 7
    do_reset();
    repeat (7) pulse(2, 2);
    settle();
    check("pre_clear_fs", int'(fs), 7);
    any_pulse_cnt = 0;
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    settle();
    check("clear_fs", int'(fs), 0);
    check("clear_no_pulses", any_pulse_cnt, 0);

    // watchdog trip and recovery
    do_reset();
    repeat (99) step(1'b0, 1'b0, 1'b0);
    settle();
    check("wd_before_limit", int'(scafal), 0);
    step(1'b0, 1'b0, 1'b0);
    settle();
    check("wd_at_limit", int'(scafal), 1);
    repeat (49) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    settle();
    check("wd_recover", int'(scafal), 0);

    // reset mid-count with FS01 high
    do_reset();
    repeat (8) pulse(2, 2);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    settle();
    check("pre_reset_fs", int'(fs), 9);
    step(1'b1, 1'b0, 1'b1);
    settle();
    check("reset_mid_outputs", int'({fs, fa, fb, scafal}), 0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    settle();
    check("high_at_release_fs", int'(fs), 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    settle();
    check("first_edge_after_reset", int'(fs), 1);

    // randomized traffic
    lvl = 1'b0;
    for (int i = 0; i < 120; i++) begin
      len = ($urandom_range(0, 15) == 0) ? $urandom_range(95, 130) : $urandom_range(1, 4);
      lvl = ~lvl;
      for (int j = 0; j < len; j++)
        step(lvl, $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
    end

    step(1'b0, 1'b0, 1'b0);
    repeat (3) settle();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
